// File: rtl/frame_update_sched_pkg.sv
// ============================================================================
// Module   : frame_update_sched_pkg
// Brief    : Shared types and helpers for the frame update scheduler.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package frame_update_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_REQ  = 2'd2
  } state_t;

  localparam int TRIGGER_ROW_DEF = 511;
  localparam int ROW_W           = 9;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_edge_det.sv
// ============================================================================
// Module   : frame_edge_det
// Brief    : Single-cycle pulse when the scan row first reaches TRIGGER_ROW.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_edge_det
  import frame_update_sched_pkg::*;
#(
  parameter int TRIGGER_ROW = TRIGGER_ROW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] row_addr,
  output logic             fb
);

  localparam logic [ROW_W-1:0] C_TRIG = ROW_W'(TRIGGER_ROW);

  logic [ROW_W-1:0] r_prev_row;

  // Resetting to the trigger row suppresses a spurious boundary right after reset.
  always_ff @(posedge clk) begin
    if (rst) r_prev_row <= C_TRIG;
    else     r_prev_row <= row_addr;
  end

  assign fb = (row_addr == C_TRIG) && (r_prev_row != C_TRIG);

endmodule

`default_nettype wire

// File: rtl/frame_update_sched.sv
// ============================================================================
// Module   : frame_update_sched
// Brief    : Per-frame fixed-priority update handshakes with per-client divisors.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_update_sched
  import frame_update_sched_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int TRIGGER_ROW = TRIGGER_ROW_DEF,
  parameter int DIV_W       = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROW_W-1:0]             row_addr,
  input  logic                         run,
  input  logic [NUM_CLIENTS*DIV_W-1:0] divisor,
  input  logic [NUM_CLIENTS-1:0]       upd_done,
  output logic [NUM_CLIENTS-1:0]       upd_req,
  output logic                         busy,
  output logic [15:0]                  frame_cnt,
  output logic                         overrun,
  output logic                         timeout_err,
  input  logic                         clr_err
);

  localparam int               C_TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT - 1);
  localparam logic [DIV_W:0]   C_ONE_EXT = (DIV_W+1)'(1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     w_fb;
  logic [NUM_CLIENTS-1:0]   r_pend;
  logic [NUM_CLIENTS-1:0]   w_wrap;
  logic [DIV_W-1:0]         r_cnt [NUM_CLIENTS];
  logic [C_TMO_W-1:0]       r_tmo;
  logic [2:0]               w_low;
  logic [NUM_CLIENTS-1:0]   w_onehot;
  logic                     w_done;
  logic                     w_tmo_hit;
  logic                     w_timeout_evt;
  logic                     w_overrun_evt;

  frame_edge_det #(
    .TRIGGER_ROW (TRIGGER_ROW)
  ) u_edge_det (
    .clk      (clk),
    .rst      (rst),
    .row_addr (row_addr),
    .fb       (w_fb)
  );

  // A zero divisor behaves as 1, so that client fires every frame.
  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      logic [DIV_W:0] w_div_eff;
      assign w_div_eff   = (divisor[gi*DIV_W +: DIV_W] == '0) ? C_ONE_EXT
                                                              : {1'b0, divisor[gi*DIV_W +: DIV_W]};
      assign w_wrap[gi]  = ({1'b0, r_cnt[gi]} + C_ONE_EXT) >= w_div_eff;
    end
  endgenerate

  assign w_low     = lowest_set(8'(r_pend));
  assign w_onehot  = NUM_CLIENTS'(1) << w_low;
  assign w_done    = |(upd_done & upd_req);
  assign w_tmo_hit = (r_tmo == C_TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_fb && run)           w_state_next = ST_SCAN;
      ST_SCAN: w_state_next = (r_pend == '0) ? ST_IDLE : ST_REQ;
      ST_REQ:  if (w_done || w_tmo_hit)   w_state_next = ST_SCAN;
      default:                            w_state_next = ST_IDLE;
    endcase
  end

  // A done pulse coinciding with the timeout is treated as a normal completion.
  always_comb begin
    busy          = (r_state != ST_IDLE);
    w_timeout_evt = (r_state == ST_REQ) && w_tmo_hit && !w_done;
    w_overrun_evt = w_fb && (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_req     <= '0;
      r_pend      <= '0;
      r_tmo       <= '0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) r_cnt[i] <= '0;
    end else begin
      if (w_fb && run) frame_cnt <= frame_cnt + 16'd1;

      if (w_overrun_evt) overrun <= 1'b1;
      else if (clr_err)  overrun <= 1'b0;

      if (w_timeout_evt) timeout_err <= 1'b1;
      else if (clr_err)  timeout_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_fb && run) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
              if (w_wrap[i]) begin
                r_pend[i] <= 1'b1;
                r_cnt[i]  <= '0;
              end else begin
                r_cnt[i]  <= r_cnt[i] + DIV_W'(1);
              end
            end
          end
        end
        ST_SCAN: begin
          if (r_pend != '0) begin
            upd_req <= w_onehot;
            r_tmo   <= '0;
          end
        end
        ST_REQ: begin
          if (w_done || w_tmo_hit) begin
            upd_req <= '0;
            r_pend  <= r_pend & ~upd_req;
          end else begin
            r_tmo   <= r_tmo + C_TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_update_sched.sv
// ============================================================================
// Module   : tb_frame_update_sched
// Brief    : Scoreboard bench for frame_update_sched with directed frames.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_update_sched;

  localparam int NC  = 4;
  localparam int DW  = 4;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [8:0]     row_addr;
  logic           run;
  logic [NC*DW-1:0] divisor;
  logic [NC-1:0]  upd_done;
  logic [NC-1:0]  upd_req;
  logic           busy;
  logic [15:0]    frame_cnt;
  logic           overrun;
  logic           timeout_err;
  logic           clr_err;

  always #5 clk = ~clk;

  frame_update_sched #(
    .NUM_CLIENTS (NC),
    .TRIGGER_ROW (511),
    .DIV_W       (DW),
    .TIMEOUT     (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_addr    (row_addr),
    .run         (run),
    .divisor     (divisor),
    .upd_done    (upd_done),
    .upd_req     (upd_req),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  typedef struct {
    logic [3:0] req;
    int         gap;   // idle samples before this request, -1 = don't care
    int         dur;   // samples the request stays high, -1 = don't care
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         ack_delay = 1;
  logic [3:0] noack_mask = 4'b0000;
  int         fires [NC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] req, input int gap, input int dur);
    exp_t e;
    e.req = req; e.gap = gap; e.dur = dur;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [3:0] mask, input int dur);
    bit first = 1'b1;
    logic [3:0] one;
    for (int i = 0; i < NC; i++) begin
      if (mask[i]) begin
        one = 4'b0001 << i;
        push(one, first ? -1 : 1, dur);
        first = 1'b0;
      end
    end
  endtask

  // Row goes 510 -> 511; the boundary is seen on the edge after this returns.
  task automatic boundary();
    @(posedge clk); #1 row_addr = 9'd510;
    @(posedge clk); #1 row_addr = 9'd511;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  // Responder: ack ack_delay samples after a request appears, unless masked.
  initial begin
    int age = 0;
    upd_done = '0;
    forever begin
      @(negedge clk);
      if (upd_req != '0) begin
        age++;
        if (age == ack_delay && (upd_req & noack_mask) == '0) upd_done = upd_req;
        else                                                  upd_done = '0;
      end else begin
        age = 0;
        upd_done = '0;
      end
    end
  end

  // Monitor: pop one expectation per new request, check order, gap and hold time.
  initial begin
    logic [3:0] prev = '0;
    int age = 0, zeros = 0, cur_dur = -1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (upd_req != prev) begin
        if (prev != '0 && cur_dur >= 0) check("req_hold_cycles", 32'(age), 32'(cur_dur));
        if (upd_req != '0) begin
          for (int i = 0; i < NC; i++) if (upd_req[i]) fires[i]++;
          if (exp_q.size() == 0) begin
            check("unexpected_req", 32'(upd_req), 32'd0);
            cur_dur = -1;
          end else begin
            e = exp_q.pop_front();
            check("req_order", 32'(upd_req), 32'(e.req));
            if (e.gap >= 0) check("req_gap", 32'(zeros), 32'(e.gap));
            cur_dur = e.dur;
          end
          age = 0;
        end
        zeros = 0;
      end
      if (upd_req != '0) age++;
      else               zeros++;
      prev = upd_req;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] masks [6];
    int n;
    masks = '{4'b1001, 4'b1011, 4'b1101, 4'b1011, 4'b1001, 4'b1111};
    for (int i = 0; i < NC; i++) fires[i] = 0;
    rst = 1'b1; row_addr = 9'd511; run = 1'b1; clr_err = 1'b0; divisor = 16'h1111;

    // Reset with row already at the trigger: nothing scheduled.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy_req", {27'd0, busy, upd_req}, 32'd0);
    end
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    check("reset_errs", {30'd0, overrun, timeout_err}, 32'd0);

    // All divisors 1, acks after 3 cycles; also check request latency.
    ack_delay = 3;
    push_frame(4'b1111, 3);
    boundary();
    @(negedge clk);
    @(negedge clk);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_scan_req", 32'(upd_req), 32'd0);
    @(negedge clk);
    check("lat_first_req", 32'(upd_req), 32'b0001);
    wait_idle();
    check("t2_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Divisors 1,2,3,0 over six frames with immediate acks.
    ack_delay = 1;
    divisor = {4'd0, 4'd3, 4'd2, 4'd1};
    for (int i = 0; i < NC; i++) fires[i] = 0;
    for (int f = 0; f < 6; f++) begin
      push_frame(masks[f], 1);
      boundary();
      wait_idle();
    end
    check("t3_fires0", 32'(fires[0]), 32'd6);
    check("t3_fires1", 32'(fires[1]), 32'd3);
    check("t3_fires2", 32'(fires[2]), 32'd2);
    check("t3_fires3", 32'(fires[3]), 32'd6);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd7);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Client1 never acks: 16-cycle timeout, then client2 served.
    divisor = 16'h1111;
    noack_mask = 4'b0010;
    push(4'b0001, -1, 1);
    push(4'b0010, 1, TMO);
    push(4'b0100, 1, 1);
    push(4'b1000, 1, 1);
    boundary();
    wait_idle();
    noack_mask = 4'b0000;
    check("t4_timeout_err", 32'(timeout_err), 32'd1);
    check("t4_overrun", 32'(overrun), 32'd0);
    check("t4_frame_cnt", 32'(frame_cnt), 32'd8);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);
    pulse_clr();
    @(negedge clk);
    check("t4_clr_timeout", 32'(timeout_err), 32'd0);

    // Second boundary while client0 is held: overrun, no extra sequence.
    pulse_rst();
    @(negedge clk);
    check("t5_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    ack_delay = 10;
    push_frame(4'b1111, 10);
    boundary();
    repeat (4) @(posedge clk);
    #1 check("t5_held_req", 32'(upd_req), 32'b0001);
    boundary();
    wait_idle();
    check("t5_overrun", 32'(overrun), 32'd1);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd2);
    check("t5_timeout_err", 32'(timeout_err), 32'd0);
    repeat (10) @(negedge clk);
    check("t5_no_extra_seq", 32'(busy), 32'd0);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    pulse_clr();
    @(negedge clk);
    check("t5_clr_overrun", 32'(overrun), 32'd0);

    // run=0: boundary is ignored entirely.
    run = 1'b0;
    boundary();
    repeat (4) @(negedge clk);
    check("run0_frame_cnt", 32'(frame_cnt), 32'd2);
    check("run0_busy", 32'(busy), 32'd0);
    run = 1'b1;

    // Reset while client2 is requested, then scheduling resumes from zero.
    ack_delay = 3;
    push(4'b0001, -1, 3);
    push(4'b0010, 1, 3);
    push(4'b0100, 1, -1);
    boundary();
    n = 0;
    while (upd_req != 4'b0100 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_req2", 32'(upd_req), 32'b0100);
    pulse_rst();
    @(negedge clk);
    check("t6_rst_outputs", {11'd0, busy, overrun, timeout_err, upd_req, frame_cnt}, 32'd0);
    push_frame(4'b1111, 3);
    boundary();
    wait_idle();
    check("t6_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
